// File: rtl/regfile_writeback.sv
// Register file write-port producer: merges the in-order pipeline writeback with buffered
// long-latency results, tracks outstanding destinations, and stalls the pipe on starvation.
// Optional macro WB_BYPASS_EN: long-latency result skips an empty FIFO and writes the same cycle.
module regfile_writeback #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_valid_i,
   input  logic [4:0]  pipe_dest_i,
   input  logic [31:0] pipe_data_i,
   input  logic        lng_valid_i,
   output logic        lng_ready_o,
   input  logic [4:0]  lng_dest_i,
   input  logic [31:0] lng_data_i,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_dest_i,
   output logic [31:0] busy_o,
   output logic        pipe_hold_o,
   output logic        rf_load_o,
   output logic [4:0]  rf_dest_o,
   output logic [31:0] rf_in_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   logic [4:0]       dest_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      busy_q, busy_d;
   logic [STV_W-1:0] starve_q, starve_d;
   logic             hold_q, hold_d;

   logic             empty;
   logic             ready;
   logic             pop;
   logic             push;
   logic             bypass;
   logic [4:0]       head_dest;
   logic [31:0]      head_data;
   logic [31:0]      clr_mask;
   logic [31:0]      set_mask;
   logic             sel_load;
   logic [4:0]       sel_dest;
   logic [31:0]      sel_data;

   // FIFO status comes from registered state only, so lng_ready never depends on lng_valid.
   always_comb begin
      empty     = (count_q == '0);
      ready     = (count_q < CNT_W'(DEPTH));
      head_dest = dest_q[rd_ptr_q];
      head_data = data_q[rd_ptr_q];
      bypass    = 1'b0;
`ifdef WB_BYPASS_EN
      bypass    = !rst && empty && !pipe_valid_i && lng_valid_i;
`endif
      pop       = !rst && !pipe_valid_i && !empty;
      push      = !rst && lng_valid_i && ready && (lng_dest_i != 5'd0) && !bypass;
   end

   always_comb begin
      sel_load = 1'b0;
      sel_dest = 5'd0;
      sel_data = 32'd0;
      if (pipe_valid_i) begin
         sel_load = (pipe_dest_i != 5'd0);
         sel_dest = pipe_dest_i;
         sel_data = pipe_data_i;
      end else if (!empty) begin
         sel_load = (head_dest != 5'd0);
         sel_dest = head_dest;
         sel_data = head_data;
      end else if (bypass) begin
         sel_load = (lng_dest_i != 5'd0);
         sel_dest = lng_dest_i;
         sel_data = lng_data_i;
      end
   end

   assign rf_load_o   = sel_load && !rst;
   assign rf_dest_o   = sel_dest;
   assign rf_in_o     = sel_data;
   assign lng_ready_o = ready;
   assign busy_o      = busy_q;
   assign pipe_hold_o = hold_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // A new issue to the same register outranks the retiring write, so set is applied last.
   always_comb begin
      clr_mask = 32'd0;
      set_mask = 32'd0;
      if (pop) begin
         clr_mask = clr_mask | (32'd1 << head_dest);
      end
      if (bypass) begin
         clr_mask = clr_mask | (32'd1 << lng_dest_i);
      end
      if (issue_valid_i && (issue_dest_i != 5'd0)) begin
         set_mask = 32'd1 << issue_dest_i;
      end
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      starve_d = '0;
      if (!empty && !pop) begin
         starve_d = (starve_q >= STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + STV_W'(1);
      end
      hold_d = hold_q;
      if (pop) begin
         hold_d = 1'b0;
      end else if (starve_q >= STV_W'(STARVE_LIMIT)) begin
         hold_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         busy_q   <= 32'd0;
         starve_q <= '0;
         hold_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         starve_q <= starve_d;
         hold_q   <= hold_d;
      end
   end

   // Entry storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         dest_q[wr_ptr_q] <= lng_dest_i;
         data_q[wr_ptr_q] <= lng_data_i;
      end
   end

`ifndef SYNTHESIS
   hold_respected: assert property (@(posedge clk) disable iff (rst) !(hold_q && pipe_valid_i));
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed scenarios followed by randomized traffic, compared against a queue-based model
// of the write-port arbitration, busy scoreboard and starvation stall.
module tb_regfile_writeback;

   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_valid;
   logic [4:0]  pipe_dest;
   logic [31:0] pipe_data;
   logic        lng_valid;
   logic        lng_ready;
   logic [4:0]  lng_dest;
   logic [31:0] lng_data;
   logic        issue_valid;
   logic [4:0]  issue_dest;
   logic [31:0] busy;
   logic        pipe_hold;
   logic        rf_load;
   logic [4:0]  rf_dest;
   logic [31:0] rf_in;

   int n_vec = 0;
   int n_err = 0;

   logic [36:0] m_q [$];
   logic [31:0] m_busy;
   logic        m_hold;
   int          m_run;

   logic        obs_load, obs_ready, obs_hold;
   logic [4:0]  obs_dest;
   logic [31:0] obs_in, obs_busy;

   regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_valid_i  (pipe_valid),
      .pipe_dest_i   (pipe_dest),
      .pipe_data_i   (pipe_data),
      .lng_valid_i   (lng_valid),
      .lng_ready_o   (lng_ready),
      .lng_dest_i    (lng_dest),
      .lng_data_i    (lng_data),
      .issue_valid_i (issue_valid),
      .issue_dest_i  (issue_dest),
      .busy_o        (busy),
      .pipe_hold_o   (pipe_hold),
      .rf_load_o     (rf_load),
      .rf_dest_o     (rf_dest),
      .rf_in_o       (rf_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit bypass_on();
`ifdef WB_BYPASS_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // One clock cycle: drive at the falling edge, check mid-cycle, advance the model at the rising edge.
   task automatic step(input logic r, input logic pv, input logic [4:0] pd, input logic [31:0] pdat,
                       input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
                       input logic iv, input logic [4:0] idst);
      logic        e_load;
      logic [4:0]  e_dest;
      logic [31:0] e_in;
      logic        byp, pop;
      logic [31:0] nb;
      logic [36:0] head;
      rst = r; pipe_valid = pv; pipe_dest = pd; pipe_data = pdat;
      lng_valid = lv; lng_dest = ld; lng_data = ldat;
      issue_valid = iv; issue_dest = idst;
      #1;
      obs_load = rf_load; obs_dest = rf_dest; obs_in = rf_in;
      obs_ready = lng_ready; obs_busy = busy; obs_hold = pipe_hold;
      byp  = bypass_on() && !pv && lv && (m_q.size() == 0);
      head = (m_q.size() > 0) ? m_q[0] : 37'd0;
      e_load = 1'b0; e_dest = 5'd0; e_in = 32'd0;
      if (pv) begin
         e_load = (pd != 0); e_dest = pd; e_in = pdat;
      end else if (m_q.size() > 0) begin
         e_load = (head[36:32] != 0); e_dest = head[36:32]; e_in = head[31:0];
      end else if (byp) begin
         e_load = (ld != 0); e_dest = ld; e_in = ldat;
      end
      if (r) begin
         chk("rf_load_in_reset", {31'd0, obs_load}, 32'd0);
      end else begin
         chk("rf_load", {31'd0, obs_load}, {31'd0, e_load});
         chk("rf_dest", {27'd0, obs_dest}, {27'd0, e_dest});
         chk("rf_in", obs_in, e_in);
         chk("lng_ready", {31'd0, obs_ready}, {31'd0, m_q.size() < DEPTH});
         chk("busy", obs_busy, m_busy);
         chk("pipe_hold", {31'd0, obs_hold}, {31'd0, m_hold});
      end
      @(posedge clk);
      if (r) begin
         m_q.delete(); m_busy = 32'd0; m_hold = 1'b0; m_run = 0;
      end else begin
         pop = !pv && (m_q.size() > 0);
         nb  = m_busy;
         if (pop) nb[head[36:32]] = 1'b0;
         if (byp) nb[ld] = 1'b0;
         if (iv && idst != 0) nb[idst] = 1'b1;
         nb[0] = 1'b0;
         m_busy = nb;
         if (pop) m_hold = 1'b0;
         else if (m_run >= STARVE_LIMIT) m_hold = 1'b1;
         if (m_q.size() > 0 && !pop) m_run = (m_run >= STARVE_LIMIT) ? m_run : m_run + 1;
         else m_run = 0;
         if (lv && (m_q.size() < DEPTH) && !byp && ld != 0) begin
            if (pop) void'(m_q.pop_front());
            m_q.push_back({ld, ldat});
         end else if (pop) begin
            void'(m_q.pop_front());
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
   endtask

   initial begin
      m_busy = 32'd0; m_hold = 1'b0; m_run = 0;
      @(negedge clk);
      step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
      step(1, 1, 5'd4, 32'h1, 1, 5'd4, 32'h2, 1, 5'd4);

      // pipeline-only path
      step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0);
      chk("pipe5_load", {31'd0, obs_load}, 32'd1);
      chk("pipe5_dest", {27'd0, obs_dest}, 32'd5);
      chk("pipe5_data", obs_in, 32'hDEADBEEF);
      step(0, 1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0, 0, 5'd0);
      chk("pipe0_load", {31'd0, obs_load}, 32'd0);

      // long-latency drain order and busy lifetime
      step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
      step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1234, 0, 5'd0);
      chk("drain_busy_set", {31'd0, obs_busy[7]}, 32'd1);
`ifndef WB_BYPASS_EN
      idle();
      chk("drain_load", {31'd0, obs_load}, 32'd1);
      chk("drain_dest", {27'd0, obs_dest}, 32'd7);
      chk("drain_data", obs_in, 32'h1234);
`endif
      idle();
      chk("drain_busy_clr", {31'd0, obs_busy[7]}, 32'd0);

      // fill and backpressure
      step(0, 1, 5'd1, 32'h11, 1, 5'd10, 32'hA, 0, 5'd0);
      step(0, 1, 5'd1, 32'h12, 1, 5'd11, 32'hB, 0, 5'd0);
      step(0, 1, 5'd1, 32'h13, 1, 5'd12, 32'hC, 0, 5'd0);
      chk("full_ready", {31'd0, obs_ready}, 32'd0);
      idle();
      chk("fifo_order0", {27'd0, obs_dest}, 32'd10);
      idle();
      chk("fifo_order1", {27'd0, obs_dest}, 32'd11);
      idle();

      // starvation stall
      step(0, 1, 5'd2, 32'h21, 1, 5'd9, 32'h99, 0, 5'd0);
      for (int i = 0; i < STARVE_LIMIT + 1; i++) begin
         step(0, 1, 5'd2, 32'h22, 0, 5'd0, 32'd0, 0, 5'd0);
      end
      chk("hold_not_early", {31'd0, obs_hold}, 32'd0);
      idle();
      chk("hold_set", {31'd0, obs_hold}, 32'd1);
      chk("starved_drain", {27'd0, obs_dest}, 32'd9);
      idle();
      chk("hold_clr", {31'd0, obs_hold}, 32'd0);

      // scoreboard set/clear race
      step(0, 1, 5'd2, 32'h31, 1, 5'd3, 32'h33, 0, 5'd0);
      step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3);
      idle();
      chk("race_busy3", {31'd0, obs_busy[3]}, 32'd1);

      // reset mid-operation
      step(0, 1, 5'd2, 32'h41, 1, 5'd3, 32'h43, 1, 5'd3);
      step(0, 1, 5'd2, 32'h42, 1, 5'd7, 32'h47, 1, 5'd7);
      step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
      chk("rst_busy_before", obs_busy, 32'h88);
      chk("rst_no_load", {31'd0, obs_load}, 32'd0);
      idle();
      chk("post_rst_busy", obs_busy, 32'd0);
      chk("post_rst_ready", {31'd0, obs_ready}, 32'd1);
      chk("post_rst_hold", {31'd0, obs_hold}, 32'd0);
      chk("post_rst_load", {31'd0, obs_load}, 32'd0);

      // randomized traffic; pipe_valid respects the stall
      for (int i = 0; i < 3000; i++) begin
         logic r, pv, lv, iv;
         int pct;
         pct = ((i / 250) % 2 == 1) ? 95 : 40;
         r   = ($urandom_range(0, 199) == 0);
         pv  = !m_hold && ($urandom_range(0, 99) < pct);
         lv  = ($urandom_range(0, 99) < 50);
         iv  = ($urandom_range(0, 99) < 40);
         step(r, pv, 5'($urandom_range(0, 15)), $urandom, lv, 5'($urandom_range(0, 15)), $urandom,
              iv, 5'($urandom_range(0, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
